// File: rtl/l2_pkg.sv
// Shared state encoding and widths for the direct-mapped, write-back L2 cache.
package l2_pkg;
  localparam int LINE_W     = 128;
  localparam int MEM_ADDR_W = 28;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPARE = 3'd1,
    ST_WBACK   = 3'd2,
    ST_FETCH   = 3'd3,
    ST_RESP    = 3'd4
  } state_t;
endpackage

// File: rtl/l2_line_store.sv
// Per-line data/tag/valid/dirty storage: asynchronous read by index, one synchronous
// write port, and asynchronous clear of the status bits on reset.
module l2_line_store
  import l2_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int IDX    = $clog2(LINES),
  parameter int TAGLEN = MEM_ADDR_W - IDX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX-1:0]    idx,
  output logic [LINE_W-1:0] rd_data,
  output logic [TAGLEN-1:0] rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  input  logic              we,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [TAGLEN-1:0] wr_tag,
  input  logic              wr_valid,
  input  logic              wr_dirty
);
  logic [LINE_W-1:0] data_r [LINES];
  logic [TAGLEN-1:0] tag_r  [LINES];
  logic [LINES-1:0]  valid_r;
  logic [LINES-1:0]  dirty_r;

  assign rd_data  = data_r[idx];
  assign rd_tag   = tag_r[idx];
  assign rd_valid = valid_r[idx];
  assign rd_dirty = dirty_r[idx];

  // Payload arrays: no reset, contents only matter once the line is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      data_r[idx] <= wr_data;
      tag_r[idx]  <= wr_tag;
    end
  end

  // Status bits: a reset during a refill or install leaves that line invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
      dirty_r <= {LINES{1'b0}};
    end else if (we) begin
      valid_r[idx] <= wr_valid;
      dirty_r[idx] <= wr_dirty;
    end
  end
endmodule

// File: rtl/l2_cache.sv
// Direct-mapped, write-back, write-allocate L2 cache between the L1 line interface
// and main memory; one outstanding request, all outputs registered.
module l2_cache
  import l2_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int TAGLEN = 28 - $clog2(LINES)
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [29:0]           addr,
  input  logic [LINE_W-1:0]     wdata,
  output logic [LINE_W-1:0]     rdata,
  output logic                  ready,
  output logic                  stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);
  localparam int IDX = $clog2(LINES);

  state_t                  state_r, state_s;
  logic [IDX-1:0]          idx_s;
  logic [TAGLEN-1:0]       tag_s;
  logic [LINE_W-1:0]       line_data_s;
  logic [TAGLEN-1:0]       line_tag_s;
  logic                    line_valid_s, line_dirty_s;
  logic                    hit_s, victim_dirty_s;
  logic                    we_s, wr_dirty_s;
  logic [LINE_W-1:0]       wr_data_s;
  logic                    rdata_ld_s, maddr_ld_s, mwdata_ld_s;
  logic [LINE_W-1:0]       rdata_nxt_s;
  logic [MEM_ADDR_W-1:0]   maddr_nxt_s;
  logic                    unused_addr_s;

  assign idx_s          = addr[IDX+1:2];
  assign tag_s          = addr[29:IDX+2];
  assign unused_addr_s  = ^addr[1:0];
  assign hit_s          = line_valid_s && (line_tag_s == tag_s);
  assign victim_dirty_s = line_valid_s && line_dirty_s;

  l2_line_store #(.LINES(LINES), .IDX(IDX), .TAGLEN(TAGLEN)) u_store (
    .clk      (clk),
    .rst      (proc_reset),
    .idx      (idx_s),
    .rd_data  (line_data_s),
    .rd_tag   (line_tag_s),
    .rd_valid (line_valid_s),
    .rd_dirty (line_dirty_s),
    .we       (we_s),
    .wr_data  (wr_data_s),
    .wr_tag   (tag_s),
    .wr_valid (1'b1),
    .wr_dirty (wr_dirty_s)
  );

  // Next state, line-store writes and datapath load enables.
  always_comb begin
    state_s     = state_r;
    we_s        = 1'b0;
    wr_data_s   = wdata;
    wr_dirty_s  = 1'b1;
    rdata_ld_s  = 1'b0;
    rdata_nxt_s = line_data_s;
    maddr_ld_s  = 1'b0;
    maddr_nxt_s = addr[29:2];
    mwdata_ld_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (read || write) state_s = ST_COMPARE;
        else               state_s = ST_IDLE;
      end
      ST_COMPARE: begin
        if (hit_s) begin
          we_s       = write;
          rdata_ld_s = !write;
          state_s    = ST_RESP;
        end else if (victim_dirty_s) begin
          maddr_ld_s  = 1'b1;
          maddr_nxt_s = {line_tag_s, idx_s};
          mwdata_ld_s = 1'b1;
          state_s     = ST_WBACK;
        end else if (write) begin
          // A full-line write needs no fetch.
          we_s    = 1'b1;
          state_s = ST_RESP;
        end else begin
          maddr_ld_s = 1'b1;
          state_s    = ST_FETCH;
        end
      end
      ST_WBACK: begin
        if (!mem_ready) begin
          state_s = ST_WBACK;
        end else if (write) begin
          we_s    = 1'b1;
          state_s = ST_RESP;
        end else begin
          maddr_ld_s = 1'b1;
          state_s    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_ready) begin
          we_s        = 1'b1;
          wr_data_s   = mem_rdata;
          wr_dirty_s  = 1'b0;
          rdata_ld_s  = 1'b1;
          rdata_nxt_s = mem_rdata;
          state_s     = ST_RESP;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register; control outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_r   <= ST_IDLE;
      ready     <= 1'b0;
      stall     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      state_r   <= state_s;
      ready     <= (state_s == ST_RESP);
      stall     <= (state_s == ST_WBACK) || (state_s == ST_FETCH);
      mem_read  <= (state_s == ST_FETCH);
      mem_write <= (state_s == ST_WBACK);
    end
  end

  // Data output registers: response line, memory address and victim line.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      rdata     <= {LINE_W{1'b0}};
      mem_addr  <= {MEM_ADDR_W{1'b0}};
      mem_wdata <= {LINE_W{1'b0}};
    end else begin
      if (rdata_ld_s)  rdata     <= rdata_nxt_s;
      if (maddr_ld_s)  mem_addr  <= maddr_nxt_s;
      if (mwdata_ld_s) mem_wdata <= line_data_s;
    end
  end
endmodule

// File: tb/tb_l2_cache.sv
// Directed bench for l2_cache: inline memory model, scoreboard queue of expected
// read lines, immediate-assertion checks on latency and memory traffic.
module tb_l2_cache;
  logic         clk = 1'b0;
  logic         proc_reset, read, write, ready, stall;
  logic         mem_read, mem_write, mem_ready;
  logic [29:0]  addr;
  logic [127:0] wdata, rdata, mem_wdata, mem_rdata;
  logic [27:0]  mem_addr;

  int total = 0;
  int bad   = 0;
  localparam int MEM_LAT = 3;

  logic [127:0] exp_q [$];
  logic [127:0] mem_model [logic [27:0]];

  int           lat, rd_n, wr_n;
  logic [27:0]  rd_addr, wr_addr;
  logic [127:0] wr_data;
  logic         stall_at_ready, stall_in_mem, both_high, memw_late;

  always #5 clk = ~clk;

  l2_cache dut (
    .clk(clk), .proc_reset(proc_reset), .read(read), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .stall(stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  function automatic logic [127:0] mem_fill(input logic [27:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {4{4'h5, a}};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One L1 request, serving memory inline; stops at ready or after a cycle budget.
  task automatic do_req(input logic is_wr, input logic [29:0] a, input logic [127:0] d,
                        input logic [127:0] exp_rd);
    int  wcnt;
    bit  done, served_wr;
    wcnt = 0; done = 1'b0; served_wr = 1'b0;
    lat = 0; rd_n = 0; wr_n = 0; rd_addr = 28'h0; wr_addr = 28'h0; wr_data = 128'h0;
    stall_at_ready = 1'b0; stall_in_mem = 1'b1; both_high = 1'b0; memw_late = 1'b0;
    if (!is_wr) exp_q.push_back(exp_rd);
    addr = a; wdata = d; write = is_wr; read = !is_wr;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(posedge clk); #1;
      if (mem_read && mem_write) both_high = 1'b1;
      if ((mem_read || mem_write) && !stall) stall_in_mem = 1'b0;
      if (mem_ready) begin
        mem_ready = 1'b0;
        wcnt = 0;
        if (served_wr && mem_write) memw_late = 1'b1;
      end else if (mem_read || mem_write) begin
        wcnt++;
        if (mem_read && wcnt == 1) begin rd_n++; rd_addr = mem_addr; end
        if (wcnt == MEM_LAT) begin
          if (mem_write) begin
            wr_n++; wr_addr = mem_addr; wr_data = mem_wdata;
            mem_model[mem_addr] = mem_wdata;
            served_wr = 1'b1;
          end else begin
            mem_rdata = mem_fill(mem_addr);
            served_wr = 1'b0;
          end
          mem_ready = 1'b1;
        end
      end
      if (ready) begin
        lat = cyc; stall_at_ready = stall; done = 1'b1;
        if (!is_wr) check("rdata", rdata, exp_q.pop_front());
        read = 1'b0; write = 1'b0;
      end
    end
    if (!done) begin
      check("timeout", 128'(done), 128'(1));
      if (!is_wr) void'(exp_q.pop_front());
      read = 1'b0; write = 1'b0; mem_ready = 1'b0;
    end
    @(posedge clk); #1;
    check("ready_pulse", 128'(ready), 128'(0));
  endtask

  task automatic check_req(input string t, input int e_lat, input int e_rd, input int e_wr);
    check({t, ".lat"},  128'(lat),  128'(e_lat));
    check({t, ".rd_n"}, 128'(rd_n), 128'(e_rd));
    check({t, ".wr_n"}, 128'(wr_n), 128'(e_wr));
    check({t, ".stall_at_ready"}, 128'(stall_at_ready), 128'(0));
    check({t, ".stall_in_mem"},   128'(stall_in_mem),   128'(1));
    check({t, ".both_high"},      128'(both_high),      128'(0));
    check({t, ".memw_late"},      128'(memw_late),      128'(0));
  endtask

  initial begin
    proc_reset = 1'b1; read = 1'b0; write = 1'b0; addr = 30'h0;
    wdata = 128'h0; mem_rdata = 128'h0; mem_ready = 1'b0;
    mem_model[28'h10]  = {16{8'hA5}};
    mem_model[28'h110] = {16{8'h3C}};
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready",     128'(ready),     128'(0));
    check("rst.stall",     128'(stall),     128'(0));
    check("rst.mem_read",  128'(mem_read),  128'(0));
    check("rst.mem_write", 128'(mem_write), 128'(0));
    check("rst.mem_addr",  128'(mem_addr),  128'(0));
    check("rst.mem_wdata", mem_wdata,       128'h0);
    check("rst.rdata",     rdata,           128'h0);
    proc_reset = 1'b0;
    @(posedge clk); #1;

    do_req(1'b0, 30'h40, 128'h0, {16{8'hA5}});
    check_req("cold_rd", 5, 1, 0);
    check("cold_rd.addr", 128'(rd_addr), 128'(28'h10));

    do_req(1'b0, 30'h40, 128'h0, {16{8'hA5}});
    check_req("hit_rd", 2, 0, 0);

    do_req(1'b1, 30'h40, 128'h1234, 128'h0);
    check_req("hit_wr", 2, 0, 0);
    do_req(1'b0, 30'h40, 128'h0, 128'h1234);
    check_req("hit_rd2", 2, 0, 0);

    do_req(1'b0, 30'h440, 128'h0, {16{8'h3C}});
    check_req("dirty_rd", 9, 1, 1);
    check("dirty_rd.wb_addr", 128'(wr_addr), 128'(28'h10));
    check("dirty_rd.wb_data", wr_data, 128'h1234);
    check("dirty_rd.rd_addr", 128'(rd_addr), 128'(28'h110));

    do_req(1'b1, 30'h8, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h0);
    check_req("clean_wr", 2, 0, 0);
    do_req(1'b0, 30'h8, 128'h0, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    check_req("clean_wr_rd", 2, 0, 0);

    do_req(1'b1, 30'h48, 128'hDEAD_BEEF_0000_0000_CAFE_F00D_0123_4567, 128'h0);
    check_req("dirty_wr", 5, 0, 1);
    check("dirty_wr.wb_addr", 128'(wr_addr), 128'(28'h2));
    check("dirty_wr.wb_data", wr_data, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    do_req(1'b0, 30'h48, 128'h0, 128'hDEAD_BEEF_0000_0000_CAFE_F00D_0123_4567);
    check_req("dirty_wr_rd", 2, 0, 0);

    // Clean miss into FETCH, then an asynchronous reset mid-fetch.
    addr = 30'h80; read = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("abort.in_fetch", 128'(mem_read), 128'(1));
    proc_reset = 1'b1;
    #1;
    check("abort.mem_read", 128'(mem_read), 128'(0));
    check("abort.stall",    128'(stall),    128'(0));
    check("abort.ready",    128'(ready),    128'(0));
    read = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    proc_reset = 1'b0;
    @(posedge clk); #1;

    do_req(1'b0, 30'h80, 128'h0, mem_fill(28'h20));
    check_req("refetch", 5, 1, 0);
    check("refetch.addr", 128'(rd_addr), 128'(28'h20));

    do_req(1'b0, 30'h40, 128'h0, 128'h1234);
    check_req("post_rst_rd", 5, 1, 0);
    do_req(1'b0, 30'h48, 128'h0, mem_fill(28'h12));
    check_req("dirty_cleared", 5, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l2_cache.md
# l2_cache

Unified second-level cache that answers the L1 data cache's line-request interface (read/write of 128-bit lines, `ready`/`stall` handshake) and refills from, or writes back to, main memory. It sits between the L1 cache and the memory model in the extended MIPS pipeline. It is direct-mapped, write-back and write-allocate, with one outstanding request.

## Interface
- `LINES`, default 16: number of lines. Power of two; `IDX = log2(LINES)`.
- `TAGLEN`, default `28-IDX`: tag width taken from line address `addr[29:2]`.
- `clk`  in  1  the single clock.
- `proc_reset`  in  1  asynchronous, active-high reset. Connects to the L1 `reset` output.
- `read`  in  1  L1 line read request. Held high until `ready` is seen.
- `write`  in  1  L1 line write-back request. Held high until `ready` is seen.
- `addr`  in  30  word address. `[1:0]` is ignored, `[IDX+1:2]` is the index, `[29:IDX+2]` is the tag.
- `wdata`  in  128  line from L1. Valid while `write` is high.
- `rdata`  out  128  line to L1. Valid in the `ready` cycle and held afterwards.
- `ready`  out  1  one-cycle completion pulse.
- `stall`  out  1  high while a memory transaction is in flight.
- `mem_read`, `mem_write`  out  1  memory requests.
- `mem_addr`  out  28  memory line address.
- `mem_wdata`  out  128  victim line.
- `mem_rdata`  in  128  refill line. Valid when `mem_ready` is high.
- `mem_ready`  in  1  one-cycle memory completion.

## Operation
- Per-line storage: data[127:0], tag, valid, dirty. On reset, all valid and dirty bits are cleared and data is don't-care.
- States:
  - IDLE: if `read|write`, go to COMPARE. If both are high, `write` has priority (L1 never does this).
  - COMPARE, hit = valid && tag match:
    - Read hit: load `rdata` from the line, go to RESP.
    - Write hit: line := `wdata`, dirty := 1, go to RESP.
    - Miss with a dirty victim: go to WBACK.
    - Clean read miss: go to FETCH.
    - Clean write miss: install `wdata` (tag, valid=1, dirty=1), go to RESP. No fetch is needed because the write covers the full line.
  - WBACK: `mem_write=1`, `mem_addr={victim tag, index}`, `mem_wdata`=victim data. On `mem_ready`:
    - Read request: go to FETCH.
    - Write request: install `wdata` dirty, go to RESP.
  - FETCH: `mem_read=1`, `mem_addr=addr[29:2]`. On `mem_ready`: line := `mem_rdata`, valid=1, dirty=0, `rdata` := `mem_rdata`, go to RESP.
  - RESP: `ready=1`, then go to IDLE.
- Request inputs are ignored outside IDLE. L1 deasserts `read`/`write` the cycle after `ready`, so IDLE never re-accepts a completed request.
- `addr`, `wdata`, `read` and `write` are stable from request to `ready` (L1 guarantees this). The block does not latch them.

## Timing
- Reset values: `ready=0`, `stall=0`, `mem_read=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`, `rdata=0`, state IDLE.
- Reset mid-transaction aborts immediately (asynchronous). Memory requests drop in the same cycle, and the line being refilled or installed stays invalid.
- All outputs are decoded from registered state and registered data. There are no combinational input-to-output paths.
- Hit: request seen in IDLE at cycle N; COMPARE at N+1; `ready` at N+2; IDLE at N+3.
- Clean read miss: FETCH from N+2. If `mem_ready` arrives at cycle M, `ready` is at M+1.
- Dirty read miss: WBACK from N+2. On `mem_ready` at M, FETCH runs from M+1 and `mem_write` drops at M+1. The FETCH `mem_ready` at K gives `ready` at K+1.
- Dirty write miss: `ready` one cycle after the WBACK `mem_ready`.
- `stall=1` exactly in WBACK and FETCH. `stall` is 0 in the RESP cycle, so L1 never misses `ready`.
- `mem_read` and `mem_write` are never high together. Each stays high through the `mem_ready` cycle and is low the next cycle.

## Structure
- Package `l2_pkg`: state encoding (IDLE, COMPARE, WBACK, FETCH, RESP), `LINE_W=128`, `MEM_ADDR_W=28`.
- Sub-module `l2_line_store`: arrays for data, tag, valid and dirty. It has asynchronous read by index, one synchronous write port (data, tag, valid, dirty) and asynchronous clear of valid and dirty on reset.
- Top `l2_cache`: FSM, hit compare, output registers.

## Test plan
- Cold read, `addr=30'h0000_0040`, memory returns `128'hA5..A5` after 3 cycles → `mem_read`, `mem_addr=28'h10`, `stall=1`; `ready` with `rdata=A5..A5`; line valid and clean.
- Repeat the same read → `ready` at N+2, no memory activity, `rdata=A5..A5`.
- Write `addr=30'h40`, `wdata=128'h1234` → hit, `ready` at N+2; a following read returns `128'h1234`; no `mem_write`.
- Read the conflicting `addr=30'h440` (same index 0, different tag) → `mem_write` with `mem_addr=28'h10`, `mem_wdata=128'h1234`; then `mem_read` with `mem_addr=28'h110`; `ready` with the refill line.
- Clean write miss to an empty index, `addr=30'h8` → no memory traffic, `ready` at N+2; a following read hits.
- Assert `proc_reset` during FETCH → `mem_read=0`, `stall=0`, `ready=0` immediately; a subsequent read of the same address refetches from memory.
